reg_scoreboard: RTL
===================

# reg_scoreboard

Per-register write-pending tracker that generates the decode-stage interlock for the five-stage MIPS pipeline. It counts in-flight writers of each general register from issue (decode → execute handshake) to retirement (write-back register-file write), and separately counts "late" writers (loads) whose result cannot yet be forwarded. Decode uses the busy outputs to hold `ds_ready_go` low; the block replaces ad-hoc compare chains against execute/memory destination fields.

## Interface
Parameters:
- `MAX_INFLIGHT`, 3: maximum simultaneous in-flight writers per register (execute, memory, write-back).
- `CNT_W`, 2: counter width; must satisfy 2^CNT_W − 1 ≥ MAX_INFLIGHT.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `flush` in 1: synchronous clear of all counters (pipeline cancel).
- `issue_valid` in 1: instruction leaves decode this cycle (ds_to_es_valid && es_allowin) and writes a GPR.
- `issue_dest` in 5: destination register of the issuing instruction.
- `issue_late` in 1: issuing instruction is a load (result available only from memory stage).
- `late_clr_valid` in 1: a load leaves execute this cycle (its data becomes forwardable next cycle).
- `late_clr_dest` in 5: destination of that load.
- `retire_valid` in 1: write-back writes the register file this cycle (rf_we).
- `retire_dest` in 5: write-back destination (rf_waddr).
- `rs_addr`, `rt_addr` in 5 each: decode-stage read addresses.
- `rs_used`, `rt_used` in 1 each: current decode instruction actually reads that operand.
- `rs_busy`, `rt_busy` out 1 each: operand not yet obtainable; decode must stall.
- `issue_full` out 1: `issue_dest`'s pending counter is at MAX_INFLIGHT; decode must not issue.
- `ds_stall` out 1: rs_busy | rt_busy | issue_full.

## Operation
- State: per register r (1..31) `pend[r]` and `late[r]`, both CNT_W bits. Register 0 is never tracked; all busy outputs for address 0 are 0; issues/clears/retires to r0 are ignored.
- Pend update per register: +1 on issue_valid to r, −1 on retire_valid to r; both in same cycle → unchanged.
- Late update per register: +1 on issue_valid && issue_late to r, −1 on late_clr_valid to r; both same cycle → unchanged.
- Issue, late-clear and retire may target the same or different registers in one cycle; each applies independently.
- Decrement of a zero counter is a protocol error: counter holds 0 (no wrap); assertion fires in simulation.
- Increment at MAX_INFLIGHT cannot occur legally because issue_full blocks it; if forced, counter saturates.
- Busy (default build): rs_busy = rs_used && rs_addr≠0 && late[rs_addr]≠0; likewise rt.
- flush: all pend/late ← 0 at next edge, overriding same-cycle issue/clear/retire.

## Timing
- All outputs combinational from registered counters and current address/used inputs; no input-to-output path through issue/clear/retire (updates visible the cycle after the event).
- Load issued cycle N → dependent decode instruction sees busy in N+1; load leaves execute (late_clr) in cycle M → busy deasserts in M+1, matching memory-stage forwarding.
- Reset values: all counters 0; rs_busy, rt_busy, issue_full, ds_stall = 0.
- Reset asserted mid-operation clears state asynchronously; outputs go to 0 without waiting for an edge.

## Configuration
- `REG_SCOREBOARD_STRICT_EN` defined: no-forwarding build; busy uses pend instead of late (rs_busy = rs_used && rs_addr≠0 && pend[rs_addr]≠0); reader proceeds the cycle after retirement.
- Undefined: forwarding build; only late (load) writers cause busy, as in Operation.

## Structure
- Shared package `pipe_pkg`: REG_NUM=32, REG_AW=5, default MAX_INFLIGHT/CNT_W, register-address typedef.
- One sub-module `sb_counter`: saturating up/down counter with inc, dec, clr, asynchronous reset; instantiated 2×31 times via generate.

## Test plan
- Reset then rs_addr=5, rs_used=1, no issues → rs_busy=0, ds_stall=0 in every cycle.
- Issue load to r8 cycle 1, rs_addr=8 cycle 2 → rs_busy=1; late_clr r8 cycle 3 → rs_busy=0 in cycle 4 (default); strict build stays 1 until retire r8 cycle 5, then 0 in cycle 6.
- Three issues to r3 without retire → issue_full=1 for issue_dest=3; retire r3 with simultaneous issue r3 → pend[3] stays 3.
- Issue/retire/late_clr all targeting r0, rt_addr=0 → all outputs 0, no counter changes.
- Load to r10 pending, flush with simultaneous issue to r10 → next cycle all counters 0, rt_busy=0 for rt_addr=10.
- Assert reset mid-stall (r7 late=1) between edges → rs_busy drops to 0 before next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file geometry, scoreboard defaults and
// the GPR address type used by the decode-stage interlock logic.
package pipe_pkg;

  localparam int unsigned REG_NUM          = 32;
  localparam int unsigned REG_AW           = 5;
  localparam int unsigned MAX_INFLIGHT_DEF = 3;
  localparam int unsigned CNT_W_DEF        = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // True when the address names a tracked register (r0 is hardwired to zero).
  function automatic logic is_tracked(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating up/down counter for one scoreboard entry.
// Ports:
//   clk, reset (async, active-high)
//   i_clr  synchronous clear, overrides inc/dec
//   i_inc  count up (saturates at MAX)
//   i_dec  count down (holds at zero; underflow flagged in simulation)
//   o_cnt  current count
module sb_counter #(
  parameter int unsigned W   = 2,
  parameter int unsigned MAX = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  // Next count: simultaneous inc and dec cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != W'(MAX)) w_cnt_nxt = r_cnt + W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  assign o_cnt = r_cnt;

  // Retiring or clearing a writer that was never issued is a protocol error.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (i_dec && !i_inc && !i_clr) |-> (r_cnt != '0));

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-GPR write-pending tracker producing the decode interlock.
// Counts in-flight writers (pend) from issue to retirement, and load writers
// (late) from issue until the load leaves execute.
// Build option: REG_SCOREBOARD_STRICT_EN -> no-forwarding build, busy follows
// pend instead of late.
// Ports:
//   clk, reset (async, active-high), flush (sync clear of all counters)
//   issue_valid/issue_dest/issue_late : writer leaves decode
//   late_clr_valid/late_clr_dest      : load leaves execute
//   retire_valid/retire_dest          : write-back RF write
//   rs_addr/rs_used, rt_addr/rt_used  : decode operand reads
//   rs_busy, rt_busy, issue_full, ds_stall : combinational interlock outputs
import pipe_pkg::*;

module reg_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_dest,
  input  logic              issue_late,
  input  logic              late_clr_valid,
  input  logic [REG_AW-1:0] late_clr_dest,
  input  logic              retire_valid,
  input  logic [REG_AW-1:0] retire_dest,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              issue_full,
  output logic              ds_stall
);

  logic [CNT_W-1:0]   w_pend [REG_NUM];
  logic [CNT_W-1:0]   w_late [REG_NUM];
  logic [REG_NUM-1:0] w_hazard;

  // r0 is never tracked.
  assign w_pend[0] = '0;
  assign w_late[0] = '0;

  // One pend and one late counter per tracked register.
  for (genvar r = 1; r < REG_NUM; r++) begin : g_reg
    logic w_iss;
    logic w_ret;
    logic w_lset;
    logic w_lclr;

    assign w_iss  = issue_valid    && (issue_dest    == REG_AW'(r));
    assign w_ret  = retire_valid   && (retire_dest   == REG_AW'(r));
    assign w_lset = w_iss          && issue_late;
    assign w_lclr = late_clr_valid && (late_clr_dest == REG_AW'(r));

    sb_counter #(.W(CNT_W), .MAX(MAX_INFLIGHT)) u_pend (
      .clk   (clk),
      .reset (reset),
      .i_clr (flush),
      .i_inc (w_iss),
      .i_dec (w_ret),
      .o_cnt (w_pend[r])
    );

    sb_counter #(.W(CNT_W), .MAX(MAX_INFLIGHT)) u_late (
      .clk   (clk),
      .reset (reset),
      .i_clr (flush),
      .i_inc (w_lset),
      .i_dec (w_lclr),
      .o_cnt (w_late[r])
    );
  end

  // Per-register "operand not obtainable" flag.
  always_comb begin
    w_hazard = '0;
    for (int r = 1; r < REG_NUM; r++) begin
`ifdef REG_SCOREBOARD_STRICT_EN
      w_hazard[r] = (w_pend[r] != '0);
`else
      w_hazard[r] = (w_late[r] != '0);
`endif
    end
  end

  assign rs_busy    = rs_used && is_tracked(rs_addr) && w_hazard[rs_addr];
  assign rt_busy    = rt_used && is_tracked(rt_addr) && w_hazard[rt_addr];
  assign issue_full = (w_pend[issue_dest] == CNT_W'(MAX_INFLIGHT));
  assign ds_stall   = rs_busy || rt_busy || issue_full;

endmodule
